// File: rtl/timer_irq_pkg.sv
// Shared constants for the timer interrupt controller: register map,
// FSM encoding and STAT field positions.
package timer_irq_pkg;

  localparam logic [1:0] ADDR_PEND = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int STAT_IRQ_BIT = 31;
  localparam int STAT_ID_LSB  = 28;
  localparam int STAT_OVR_LSB = 16;
  localparam int STAT_ST_LSB  = 8;
  localparam int STAT_LVL_LSB = 0;

endpackage

// File: rtl/irq_edge_sync.sv
// One channel: multi-flop synchronizer followed by an edge register and
// a selectable rising/falling edge detector.
module irq_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic fall_sel,
  output logic level,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign pulse = fall_sel ? (prev & ~level) : (~prev & level);

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer channel interrupt controller with PEND/MASK/EDGE/STAT registers.
// Define TIMER_IRQ_OVR_EN to build the sticky per-channel overrun flags.
module timer_irq_ctrl
  import timer_irq_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] cnt_out,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              irq,
  output logic [1:0]        irq_id,
  input  logic              irq_ack
);

  logic [NUM_CH-1:0] pend, mask, edge_cfg;
  logic [NUM_CH-1:0] lvl, hit, req;
  logic [NUM_CH-1:0] wclr, ack_clr;
  logic [3:0]        lvl4, ovr4;
  logic [1:0]        low_id;
  logic              ack_hit;
  logic              wdata_unused;

  state_e     state_q, state_d;
  logic       irq_q, irq_d;
  logic [1:0] id_q, id_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    irq_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .din     (cnt_out[g]),
      .fall_sel(edge_cfg[g]),
      .level   (lvl[g]),
      .pulse   (hit[g])
    );
  end

  assign wdata_unused = ^wdata[31:NUM_CH];
  assign wclr = (we && addr == ADDR_PEND) ? wdata[NUM_CH-1:0] : '0;
  assign req  = pend & mask;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_CH; i++)
      ack_clr[i] = ack_hit && (id_q == 2'(i));
  end

  // New edges are OR'd in last so a same-cycle set beats any clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend     <= '0;
      mask     <= '0;
      edge_cfg <= '0;
    end else begin
      pend <= (pend & ~wclr & ~ack_clr) | hit;
      if (we && addr == ADDR_MASK) mask <= wdata[NUM_CH-1:0];
      if (we && addr == ADDR_EDGE) edge_cfg <= wdata[NUM_CH-1:0];
    end
  end

`ifdef TIMER_IRQ_OVR_EN
  logic [NUM_CH-1:0] ovr;

  always_ff @(posedge clk) begin
    if (!rst) ovr <= '0;
    else      ovr <= (ovr & ~wclr) | (hit & pend);
  end

  always_comb begin
    ovr4 = '0;
    ovr4[NUM_CH-1:0] = ovr;
  end
`else
  assign ovr4 = '0;
`endif

  always_comb begin
    low_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (req[i]) low_id = 2'(i);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    id_d    = id_q;
    ack_hit = 1'b0;
    unique case (state_q)
      ST_IDLE: if (|req) begin
        state_d = ST_REQ;
        irq_d   = 1'b1;
        id_d    = low_id;
      end
      ST_REQ: if (irq_ack) begin
        state_d = ST_GAP;
        irq_d   = 1'b0;
        ack_hit = 1'b1;
      end
      ST_GAP: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  assign irq    = irq_q;
  assign irq_id = id_q;

  always_comb begin
    lvl4 = '0;
    lvl4[NUM_CH-1:0] = lvl;
  end

  always_comb begin
    rdata = '0;
    unique case (addr)
      ADDR_PEND: rdata[NUM_CH-1:0] = pend;
      ADDR_MASK: rdata[NUM_CH-1:0] = mask;
      ADDR_EDGE: rdata[NUM_CH-1:0] = edge_cfg;
      ADDR_STAT: begin
        rdata[STAT_IRQ_BIT]      = irq_q;
        rdata[STAT_ID_LSB +: 2]  = id_q;
        rdata[STAT_OVR_LSB +: 4] = ovr4;
        rdata[STAT_ST_LSB +: 2]  = state_q;
        rdata[STAT_LVL_LSB +: 4] = lvl4;
      end
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed vector bench for timer_irq_ctrl (default NUM_CH=3, SYNC_STAGES=2).
module tb_timer_irq_ctrl;

  localparam logic [1:0] P = 2'd0;
  localparam logic [1:0] M = 2'd1;
  localparam logic [1:0] E = 2'd2;
  localparam logic [1:0] S = 2'd3;
  localparam logic [31:0] F  = 32'hFFFF_FFFF;
  localparam logic [31:0] NI = 32'hCFFF_FFFF;
`ifdef TIMER_IRQ_OVR_EN
  localparam logic [31:0] OVR0 = 32'h0001_0000;
`else
  localparam logic [31:0] OVR0 = 32'h0;
`endif

  logic        clk = 0;
  logic        rst = 0;
  logic [2:0]  cnt_out = 0;
  logic        we = 0;
  logic [1:0]  addr = 0;
  logic [31:0] wdata = 0;
  logic [31:0] rdata;
  logic        irq;
  logic [1:0]  irq_id;
  logic        irq_ack = 0;

  int errors = 0;
  int checks = 0;

  timer_irq_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .cnt_out(cnt_out),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq),
    .irq_id (irq_id),
    .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  cnt;
    logic        ack;
    logic [1:0]  raddr;
    logic [31:0] msk;
    logic [31:0] exp;
    logic        eirq;
    logic [1:0]  eid;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic w, logic [1:0] a, logic [31:0] d,
                             logic [2:0] c, logic k, logic [1:0] ra,
                             logic [31:0] mk, logic [31:0] ex,
                             logic ei, logic [1:0] eid);
    vec_t r;
    r.we = w; r.addr = a; r.wdata = d; r.cnt = c; r.ack = k;
    r.raddr = ra; r.msk = mk; r.exp = ex; r.eirq = ei; r.eid = eid;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    we = 0; irq_ack = 0;
    @(posedge clk); #1;
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    @(negedge clk);
    we = 1; addr = a; wdata = d; irq_ack = 0;
    @(posedge clk); #1;
    we = 0;
  endtask

  task automatic rd(logic [1:0] a, string name, logic [31:0] want);
    addr = a; #1;
    chk(name, rdata, want);
  endtask

  initial begin
    tbl.push_back(v(0, P, 0, 3'b000, 0, S, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b000, 0, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b000, 0, M, F, 32'h0, 0, 0));
    tbl.push_back(v(1, M, F, 3'b000, 0, M, F, 32'h7, 0, 0));
    tbl.push_back(v(1, E, 0, 3'b000, 0, E, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b010, 0, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b010, 0, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b010, 0, P, F, 32'h2, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b010, 0, S, F, 32'h9000_0102, 1, 1));
    tbl.push_back(v(1, M, 0, 3'b010, 0, S, F, 32'h9000_0102, 1, 1));
    tbl.push_back(v(0, P, 0, 3'b010, 0, M, F, 32'h0, 1, 1));
    tbl.push_back(v(0, P, 0, 3'b010, 1, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b010, 0, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b010, 0, S, NI, 32'h2, 0, 0));
    tbl.push_back(v(1, E, 32'h4, 3'b010, 0, E, F, 32'h4, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b110, 0, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b110, 0, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b110, 0, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b010, 0, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b010, 0, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b010, 0, P, F, 32'h4, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b011, 0, P, F, 32'h4, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b011, 0, P, F, 32'h4, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b011, 0, P, F, 32'h5, 0, 0));
    tbl.push_back(v(1, M, F, 3'b011, 0, P, F, 32'h5, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b011, 0, S, F, 32'h8000_0103, 1, 0));
    tbl.push_back(v(0, P, 0, 3'b011, 1, P, F, 32'h4, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b011, 1, S, NI, 32'h3, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b011, 0, S, F, 32'hA000_0103, 1, 2));
    tbl.push_back(v(0, P, 0, 3'b011, 1, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b011, 0, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b011, 0, S, NI, 32'h3, 0, 0));
    tbl.push_back(v(1, M, 0, 3'b011, 0, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b010, 0, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b010, 0, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b011, 0, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b011, 0, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b011, 0, P, F, 32'h1, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b010, 0, P, F, 32'h1, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b010, 0, P, F, 32'h1, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b011, 0, P, F, 32'h1, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b011, 0, P, F, 32'h1, 0, 0));
    tbl.push_back(v(1, P, 32'h1, 3'b011, 0, P, F, 32'h1, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b011, 0, S, NI, 32'h3 | OVR0, 0, 0));
    tbl.push_back(v(1, P, 32'h1, 3'b011, 0, P, F, 32'h0, 0, 0));
    tbl.push_back(v(0, P, 0, 3'b011, 0, S, NI, 32'h3, 0, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      we = tbl[i].we; addr = tbl[i].addr; wdata = tbl[i].wdata;
      cnt_out = tbl[i].cnt; irq_ack = tbl[i].ack;
      @(posedge clk); #1;
      we = 0; irq_ack = 0; addr = tbl[i].raddr; #1;
      chk($sformatf("vec%0d rdata", i), rdata & tbl[i].msk, tbl[i].exp);
      chk($sformatf("vec%0d irq", i), 32'(irq), 32'(tbl[i].eirq));
      if (tbl[i].eirq)
        chk($sformatf("vec%0d irq_id", i), 32'(irq_id), 32'(tbl[i].eid));
    end

    // Drive the block into REQ on channel 1, then reset mid-request
    wr(E, 32'h7);
    @(negedge clk);
    cnt_out = 3'b001;
    cyc(); cyc(); cyc();
    rd(P, "seq pend ch1 fall", 32'h2);
    wr(M, 32'h7);
    cyc();
    chk("seq irq before rst", 32'(irq), 32'h1);
    chk("seq id before rst", 32'(irq_id), 32'h1);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("rst irq", 32'(irq), 32'h0);
    chk("rst irq_id", 32'(irq_id), 32'h0);
    rd(S, "rst stat", 32'h0);
    rd(P, "rst pend", 32'h0);
    rd(M, "rst mask", 32'h0);
    rd(E, "rst edge", 32'h0);
    @(negedge clk);
    rst = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_irq_ctrl.md
TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001 Parameter NUM_CH, default 3: number of counter OUT channels handled (1..4).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per channel (>=2).
REQ-003 clk  input  1  sole clock; every register in the block samples on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low (0 on a clk rising edge resets the block).
REQ-005 cnt_out  input  NUM_CH  counter channel OUT levels (counterN_OUT), asynchronous to clk.
REQ-006 we  input  1  bus write strobe, one clk per write.
REQ-007 addr  input  2  register select: 0 PEND, 1 MASK, 2 EDGE, 3 STAT.
REQ-008 wdata  input  32  bus write data.
REQ-009 rdata  output  32  combinational read of the register selected by addr.
REQ-010 irq  output  1  registered interrupt request to the CPU.
REQ-011 irq_id  output  2  registered index of the channel being requested; valid while irq=1.
REQ-012 irq_ack  input  1  CPU acknowledge, one-clk pulse.

Function
REQ-013 Each cnt_out bit SHALL pass through SYNC_STAGES flops, then one edge register; EDGE[i]=0 selects the rising edge, EDGE[i]=1 selects the falling edge.
REQ-014 A selected edge SHALL set PEND[i] exactly SYNC_STAGES+1 clks after the input change is sampled.
REQ-015 A PEND write SHALL be write-1-to-clear on bits [NUM_CH-1:0]; MASK and EDGE writes SHALL load bits [NUM_CH-1:0]; STAT writes SHALL be ignored.
REQ-016 Unused rdata bits SHALL read 0. STAT SHALL read {irq at bit 31, irq_id at [29:28], OVR at [19:16], state at [9:8], synced levels at [3:0]}.
REQ-017 If an edge and a PEND clear of the same bit occur in the same clk, the set SHALL win.
REQ-018 The FSM SHALL have states IDLE, REQ and GAP, encoded 0, 1 and 2 in STAT.
REQ-019 IDLE: when (PEND & MASK) != 0, go to REQ next clk, assert irq, and latch irq_id to the lowest set index.
REQ-020 REQ: irq=1 and irq_id are frozen; this holds even if MASK or PEND change. On irq_ack, clear PEND[irq_id], drop irq, and go to GAP.
REQ-021 If PEND[irq_id] is cleared by a bus write while in REQ, the block SHALL still wait for irq_ack (no spurious withdrawal).
REQ-022 GAP: irq=0 for exactly one clk, then go to IDLE; this guarantees a visible deassertion between back-to-back requests.
REQ-023 irq_ack outside REQ SHALL be ignored.
REQ-024 An irq_ack and a new edge on the same channel in the same clk SHALL leave PEND set (set wins).

Reset
REQ-025 On reset: PEND=0, MASK=0, EDGE=0, OVR=0, synchronizer and edge flops=0, state=IDLE, irq=0, irq_id=0.
REQ-026 Reset in any state, including REQ, SHALL take effect on that clk edge; no ack is required.

Configuration
REQ-027 With TIMER_IRQ_OVR_EN defined: a selected edge on a channel whose PEND is already 1 SHALL set sticky OVR[i]; OVR[i] SHALL be cleared when a 1 is written to PEND bit i.
REQ-028 Without TIMER_IRQ_OVR_EN: no OVR storage is built and the OVR field reads 0.

Structure
REQ-029 Package timer_irq_pkg SHALL hold the register address constants, the state encoding, and the STAT field bit positions.
REQ-030 Sub-module irq_edge_sync SHALL implement one channel's synchronizer and edge detector; it is instantiated NUM_CH times.

Verification
REQ-031 MASK=3'b111, EDGE=0; cnt_out[1] goes 0->1 -> PEND=3'b010 after 3 clks; irq=1 and irq_id=1 one clk later.
REQ-032 PEND=3'b101, all masked in -> irq_id=0; ack -> 1 clk of irq=0 (GAP), then irq_id=2; ack -> PEND=0 and irq stays 0.
REQ-033 EDGE[2]=1; a rising cnt_out[2] -> no PEND; a falling cnt_out[2] -> PEND[2]=1.
REQ-034 PEND[0] set, write PEND=32'h1 in the same clk as a new channel-0 edge -> PEND[0] remains 1; with TIMER_IRQ_OVR_EN, OVR[0]=1.
REQ-035 In REQ with irq_id=1, write MASK=0 -> irq stays 1 until ack; after ack, irq stays 0.
REQ-036 rst=0 held for one clk while in REQ -> next clk irq=0, state=IDLE, all registers 0.
